// File: rtl/zynq_reg_bank.sv
// zynq_reg_bank: PS-PL register bank with RW control registers, RO status
// registers and a sticky, maskable interrupt pair. Every output is registered.
module zynq_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_REGS   = 32,
  parameter int NUM_CTRL   = 16
) (
  input  logic                                          ps_clk,
  input  logic                                          ps_rst,
  input  logic                                          wr_en,
  input  logic [ADDR_WIDTH-1:0]                         wr_addr,
  input  logic [DATA_WIDTH-1:0]                         wr_data,
  input  logic [DATA_WIDTH/8-1:0]                       wr_strb,
  input  logic                                          rd_en,
  input  logic [ADDR_WIDTH-1:0]                         rd_addr,
  output logic [DATA_WIDTH-1:0]                         rd_data,
  output logic                                          rd_valid,
  output logic [NUM_CTRL*DATA_WIDTH-1:0]                ctrl_out,
  output logic [NUM_CTRL-1:0]                           ctrl_wr_pulse,
  input  logic [(NUM_REGS-2-NUM_CTRL)*DATA_WIDTH-1:0]   status_in,
  input  logic [DATA_WIDTH-1:0]                         irq_evt,
  output logic                                          irq
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int NUM_STAT = NUM_REGS - 2 - NUM_CTRL;

  localparam logic [IDX_W-1:0]      IRQ_STAT_IDX = IDX_W'(NUM_REGS - 2);
  localparam logic [IDX_W-1:0]      IRQ_EN_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_MASK     = ADDR_WIDTH'(((1 << IDX_W) - 1) << ADDR_LSB);

  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] wr_mask;

  logic [DATA_WIDTH-1:0] ctrl_q [NUM_CTRL];
  logic [DATA_WIDTH-1:0] ctrl_d [NUM_CTRL];
  logic [NUM_CTRL-1:0]   pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [DATA_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [DATA_WIDTH-1:0] irq_clr;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  // Address bits outside the word index are don't-care; every address aliases a register.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr & ~IDX_MASK, rd_addr & ~IDX_MASK};

  assign wr_idx = wr_addr[ADDR_LSB +: IDX_W];
  assign rd_idx = rd_addr[ADDR_LSB +: IDX_W];

  // Expand the byte strobes into a per-bit write mask.
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end
  end

  // Control register next state and write pulses; a zero-strobe write still pulses.
  always_comb begin
    pulse_d = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      ctrl_d[k] = ctrl_q[k];
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        ctrl_d[k]  = (ctrl_q[k] & ~wr_mask) | (wr_data & wr_mask);
        pulse_d[k] = 1'b1;
      end
    end
  end

  // Interrupt status is sticky W1C with set priority; enable is plain byte-strobed RW.
  always_comb begin
    irq_clr  = '0;
    irq_en_d = irq_en_q;
    if (wr_en && (wr_idx == IRQ_STAT_IDX)) begin
      irq_clr = wr_data & wr_mask;
    end
    if (wr_en && (wr_idx == IRQ_EN_IDX)) begin
      irq_en_d = (irq_en_q & ~wr_mask) | (wr_data & wr_mask);
    end
    irq_stat_d = (irq_stat_q & ~irq_clr) | irq_evt;
    irq_d      = |(irq_stat_q & irq_en_q);
  end

  // Flat view of all registers as seen before this cycle's writes, for the read mux.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_view[i] = '0;
    end
    for (int k = 0; k < NUM_CTRL; k++) begin
      reg_view[k] = ctrl_q[k];
    end
    for (int s = 0; s < NUM_STAT; s++) begin
      reg_view[NUM_CTRL + s] = status_in[s*DATA_WIDTH +: DATA_WIDTH];
    end
    reg_view[NUM_REGS-2] = irq_stat_q;
    reg_view[NUM_REGS-1] = irq_en_q;
  end

  // Read data holds its last value when no read is requested.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = reg_view[rd_idx];
    end
  end

  // State update; reset wins over any concurrent access or event.
  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k] <= '0;
      end
      pulse_q    <= '0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k] <= ctrl_d[k];
      end
      pulse_q    <= pulse_d;
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
      assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
    end
  endgenerate

  assign ctrl_wr_pulse = pulse_q;
  assign irq           = irq_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;

endmodule

// File: tb/tb_zynq_reg_bank.sv
// tb_zynq_reg_bank: directed self-checking bench for zynq_reg_bank at default parameters.
module tb_zynq_reg_bank;

  localparam int DW       = 32;
  localparam int AW       = 7;
  localparam int NREGS    = 32;
  localparam int NCTRL    = 16;
  localparam int NSTAT    = NREGS - 2 - NCTRL;
  localparam int IDX_STAT = NREGS - 2;
  localparam int IDX_EN   = NREGS - 1;

  logic                 ps_clk = 1'b0;
  logic                 ps_rst;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [DW/8-1:0]      wr_strb;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [DW-1:0]        rd_data;
  logic                 rd_valid;
  logic [NCTRL*DW-1:0]  ctrl_out;
  logic [NCTRL-1:0]     ctrl_wr_pulse;
  logic [NSTAT*DW-1:0]  status_in;
  logic [DW-1:0]        irq_evt;
  logic                 irq;

  int n_compared   = 0;
  int n_mismatched = 0;

  zynq_reg_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NREGS), .NUM_CTRL(NCTRL)
  ) dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse),
    .status_in(status_in), .irq_evt(irq_evt), .irq(irq)
  );

  always #5 ps_clk = ~ps_clk;

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic cycle();
    @(posedge ps_clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int idx);
    return AW'(idx * 4);
  endfunction

  task automatic set_write(input int idx, input logic [DW-1:0] data, input logic [3:0] strb);
    wr_en   = 1'b1;
    wr_addr = addr_of(idx);
    wr_data = data;
    wr_strb = strb;
  endtask

  task automatic clear_inputs();
    wr_en   = 1'b0;
    wr_data = '0;
    wr_strb = '0;
    rd_en   = 1'b0;
    irq_evt = '0;
  endtask

  function automatic logic [DW-1:0] ctrl_reg(input int k);
    return ctrl_out[k*DW +: DW];
  endfunction

  task automatic test_reset();
    ps_rst = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    n_compared++;
    if (irq !== 1'b0 || ctrl_wr_pulse !== 16'h0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: irq=%b pulse=%h rd_valid=%b rd_data=%h required 0/0/0/0",
               irq, ctrl_wr_pulse, rd_valid, rd_data);
    end
    ps_rst = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      rd_en   = 1'b1;
      rd_addr = addr_of(i);
      cycle();
      n_compared++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h0 || irq !== 1'b0 || ctrl_wr_pulse !== 16'h0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_read_%0d: valid=%b data=%h irq=%b pulse=%h required 1/0/0/0",
                 i, rd_valid, rd_data, irq, ctrl_wr_pulse);
      end
    end
    rd_en = 1'b0;
    cycle();
    n_compared++;
    if (rd_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid_drop: rd_valid=%b required 0", rd_valid);
    end
  endtask

  task automatic test_byte_strobe();
    set_write(3, 32'hAABBCCDD, 4'hF);
    cycle();
    n_compared++;
    if (ctrl_reg(3) !== 32'hAABBCCDD || ctrl_wr_pulse !== 16'h0008) begin
      n_mismatched++;
      $display("[TB] FAIL strobe_full: reg3=%h pulse=%h required aabbccdd/0008", ctrl_reg(3), ctrl_wr_pulse);
    end
    set_write(3, 32'h11223344, 4'h5);
    cycle();
    n_compared++;
    if (ctrl_reg(3) !== 32'hAA22CC44 || ctrl_wr_pulse !== 16'h0008) begin
      n_mismatched++;
      $display("[TB] FAIL strobe_partial: reg3=%h pulse=%h required aa22cc44/0008", ctrl_reg(3), ctrl_wr_pulse);
    end
    set_write(7, 32'hFFFFFFFF, 4'h0);
    cycle();
    n_compared++;
    if (ctrl_reg(7) !== 32'h0 || ctrl_wr_pulse !== 16'h0080 || ctrl_reg(3) !== 32'hAA22CC44) begin
      n_mismatched++;
      $display("[TB] FAIL strobe_zero: reg7=%h pulse=%h reg3=%h required 0/0080/aa22cc44",
               ctrl_reg(7), ctrl_wr_pulse, ctrl_reg(3));
    end
    clear_inputs();
    cycle();
    n_compared++;
    if (ctrl_wr_pulse !== 16'h0) begin
      n_mismatched++;
      $display("[TB] FAIL pulse_drop: pulse=%h required 0000", ctrl_wr_pulse);
    end
  endtask

  task automatic test_collision();
    set_write(5, 32'h1, 4'hF);
    cycle();
    set_write(5, 32'h2, 4'hF);
    rd_en   = 1'b1;
    rd_addr = addr_of(5);
    cycle();
    wr_en = 1'b0;
    n_compared++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h1) begin
      n_mismatched++;
      $display("[TB] FAIL collision_old: valid=%b data=%h required 1/00000001", rd_valid, rd_data);
    end
    cycle();
    rd_en = 1'b0;
    n_compared++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h2) begin
      n_mismatched++;
      $display("[TB] FAIL collision_new: valid=%b data=%h required 1/00000002", rd_valid, rd_data);
    end
    cycle();
    n_compared++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h2) begin
      n_mismatched++;
      $display("[TB] FAIL read_hold: valid=%b data=%h required 0/00000002", rd_valid, rd_data);
    end
  endtask

  task automatic test_status();
    status_in[0 +: DW]             = 32'hDEADBEEF;
    status_in[(NSTAT-1)*DW +: DW]  = 32'h12345678;
    set_write(NCTRL, 32'h0, 4'hF);
    cycle();
    n_compared++;
    if (ctrl_wr_pulse !== 16'h0) begin
      n_mismatched++;
      $display("[TB] FAIL status_no_pulse: pulse=%h required 0000", ctrl_wr_pulse);
    end
    clear_inputs();
    rd_en   = 1'b1;
    rd_addr = addr_of(NCTRL);
    cycle();
    rd_en = 1'b0;
    n_compared++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL status_read0: valid=%b data=%h required 1/deadbeef", rd_valid, rd_data);
    end
    rd_en   = 1'b1;
    rd_addr = addr_of(NCTRL + NSTAT - 1) | 7'h03;
    cycle();
    rd_en = 1'b0;
    n_compared++;
    if (rd_data !== 32'h12345678) begin
      n_mismatched++;
      $display("[TB] FAIL status_read_last: data=%h required 12345678", rd_data);
    end
  endtask

  task automatic test_interrupt();
    set_write(IDX_EN, 32'h4, 4'hF);
    cycle();
    clear_inputs();
    irq_evt = 32'h6;
    cycle();
    irq_evt = '0;
    n_compared++;
    if (irq !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL irq_early: irq=%b required 0", irq);
    end
    cycle();
    n_compared++;
    if (irq !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL irq_rise: irq=%b required 1", irq);
    end
    rd_en   = 1'b1;
    rd_addr = addr_of(IDX_STAT);
    cycle();
    rd_en = 1'b0;
    n_compared++;
    if (rd_data !== 32'h6) begin
      n_mismatched++;
      $display("[TB] FAIL irq_stat_set: data=%h required 00000006", rd_data);
    end
    set_write(IDX_STAT, 32'h4, 4'hF);
    cycle();
    wr_en = 1'b0;
    n_compared++;
    if (irq !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL irq_hold: irq=%b required 1", irq);
    end
    cycle();
    n_compared++;
    if (irq !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL irq_fall: irq=%b required 0", irq);
    end
    rd_en   = 1'b1;
    rd_addr = addr_of(IDX_STAT);
    cycle();
    rd_en = 1'b0;
    n_compared++;
    if (rd_data !== 32'h2) begin
      n_mismatched++;
      $display("[TB] FAIL irq_stat_w1c: data=%h required 00000002", rd_data);
    end
  endtask

  task automatic test_race();
    set_write(IDX_STAT, 32'h1, 4'hF);
    irq_evt = 32'h1;
    cycle();
    clear_inputs();
    set_write(IDX_STAT, 32'h2, 4'h0);
    cycle();
    clear_inputs();
    rd_en   = 1'b1;
    rd_addr = addr_of(IDX_STAT);
    cycle();
    rd_en = 1'b0;
    n_compared++;
    if (rd_data !== 32'h3) begin
      n_mismatched++;
      $display("[TB] FAIL set_wins_and_strobe_gate: data=%h required 00000003", rd_data);
    end
  endtask

  task automatic test_reset_mid_read();
    set_write(IDX_EN, 32'h2, 4'hF);
    cycle();
    clear_inputs();
    cycle();
    n_compared++;
    if (irq !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL irq_pre_reset: irq=%b required 1", irq);
    end
    rd_en   = 1'b1;
    rd_addr = addr_of(3);
    ps_rst  = 1'b1;
    set_write(4, 32'hFFFFFFFF, 4'hF);
    irq_evt = 32'hFF;
    cycle();
    clear_inputs();
    ps_rst = 1'b0;
    n_compared++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0 || irq !== 1'b0 || ctrl_wr_pulse !== 16'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid_read: valid=%b data=%h irq=%b pulse=%h required 0/0/0/0",
               rd_valid, rd_data, irq, ctrl_wr_pulse);
    end
    n_compared++;
    if (ctrl_out !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctrl_out: reg3=%h reg4=%h reg5=%h required all 0",
               ctrl_reg(3), ctrl_reg(4), ctrl_reg(5));
    end
    for (int i = IDX_STAT; i <= IDX_EN; i++) begin
      rd_en   = 1'b1;
      rd_addr = addr_of(i);
      cycle();
      n_compared++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_irq_reg_%0d: valid=%b data=%h required 1/0", i, rd_valid, rd_data);
      end
    end
    rd_en = 1'b0;
    cycle();
  endtask

  initial begin
    ps_rst    = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_strb   = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    status_in = '0;
    irq_evt   = '0;
    test_reset();
    test_byte_strobe();
    test_collision();
    test_status();
    test_interrupt();
    test_race();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
